// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte FIFO sitting between a UART receiver and a bus
//   interface. The FIFO always accepts the receiver's hand-off. When it is
//   full, the byte is dropped and a sticky overrun flag is set. It also
//   provides a level-threshold interrupt and an optional character-timeout
//   interrupt.
//
//   Optional feature macro: UART_RX_FIFO_TIMEOUT_EN
//     When it is defined, the character-timeout counter and interrupt are
//     built. When it is undefined, timeout_irq_o is tied low.
//
// Parameters
//   DEPTH           FIFO entries; must be a power of two and at least 2
//   TIMEOUT_CYCLES  idle clk cycles with data held before timeout_irq_o
//
// Ports
//   clk            clock; all logic runs on its rising edge
//   rst            synchronous reset, active low
//   cfg_en_i       UART enable; while low, the FIFO is flushed and held empty
//   in_data_i      received byte
//   in_valid_i     in_data_i is valid
//   in_ready_o     byte accepted or dropped this cycle (equals cfg_en_i)
//   rd_en_i        pop strobe from the bus side
//   rd_data_o      head entry, first-word fall-through
//   empty_o        level is 0
//   full_o         level equals DEPTH
//   level_o        number of stored entries
//   thresh_i       threshold for the level interrupt (0 disables it)
//   thresh_irq_o   registered: level_o >= thresh_i
//   overrun_o      sticky; a byte was dropped
//   clr_overrun_i  clears overrun_o
//   timeout_irq_o  character-timeout interrupt
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_en_i,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         rd_en_i,
  output logic [7:0]                   rd_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH):0]       level_o,
  input  logic [$clog2(DEPTH):0]       thresh_i,
  output logic                         thresh_irq_o,
  output logic                         overrun_o,
  input  logic                         clr_overrun_i,
  output logic                         timeout_irq_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYCLES must be at least 1");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  assign in_ready_o = cfg_en_i;
  assign level_o    = level;
  assign empty_o    = (level == '0);
  assign full_o     = (level == (AW + 1)'(DEPTH));
  assign rd_data_o  = mem[rd_ptr];

  // When the FIFO is full and a pop happens in the same cycle, the freed
  // slot takes the incoming byte. The write lands on the slot being popped,
  // and that slot is read combinationally before the edge.
  assign do_pop  = cfg_en_i & rd_en_i & ~empty_o;
  assign do_push = cfg_en_i & in_valid_i & (~full_o | rd_en_i);
  assign drop    = cfg_en_i & in_valid_i & full_o & ~rd_en_i;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst || !cfg_en_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Setting overrun wins over clearing it. The flag also holds its value
  // while the UART is disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_o <= 1'b0;
    end else if (drop) begin
      overrun_o <= 1'b1;
    end else if (clr_overrun_i && cfg_en_i) begin
      overrun_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      thresh_irq_o <= 1'b0;
    end else begin
      thresh_irq_o <= (thresh_i != '0) && (level >= thresh_i);
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          to_irq;

  // Down-counter reloaded on any activity. The last idle decrement raises
  // the interrupt, and the counter then parks at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else if (!cfg_en_i || empty_o || do_push || do_pop) begin
      to_cnt <= TW'(TIMEOUT_CYCLES);
      to_irq <= 1'b0;
    end else if (to_cnt == TW'(1)) begin
      to_cnt <= '0;
      to_irq <= 1'b1;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  assign timeout_irq_o = to_irq;
`else
  assign timeout_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en_i;
  logic [7:0]    in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          rd_en_i;
  logic [7:0]    rd_data_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   level_o;
  logic [AW:0]   thresh_i;
  logic          thresh_irq_o;
  logic          overrun_o;
  logic          clr_overrun_i;
  logic          timeout_irq_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cfg_en_i(cfg_en_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o),
    .level_o(level_o), .thresh_i(thresh_i), .thresh_irq_o(thresh_irq_o),
    .overrun_o(overrun_o), .clr_overrun_i(clr_overrun_i),
    .timeout_irq_o(timeout_irq_o)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and update the reference queue.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic rd);
    bit popped;
    in_valid_i = v;
    in_data_i  = d;
    rd_en_i    = rd;
    popped = rd && cfg_en_i && rst && (sb.size() > 0);
    @(posedge clk);
    if (cfg_en_i && rst) begin
      if (popped) void'(sb.pop_front());
      if (v && sb.size() < DEPTH) sb.push_back(d);
    end
    #1;
    in_valid_i = 1'b0;
    rd_en_i    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; cfg_en_i = 1'b1;
    idle(2);
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    vectors++; if (full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full_o); end
    vectors++; if (level_o !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    vectors++; if (thresh_irq_o !== 1'b0) begin miscompares++; $display("FAIL reset_thresh_irq: got %b want 0", thresh_irq_o); end
    vectors++; if (timeout_irq_o !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_irq: got %b want 0", timeout_irq_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL ready_enabled: got %b want 1", in_ready_o); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    drive_cycle(1'b1, 8'h55, 1'b0);
    drive_cycle(1'b1, 8'hAA, 1'b0);
    vectors++; if (level_o !== 5'd2) begin miscompares++; $display("FAIL basic_level2: got %0d want 2", level_o); end
    vectors++; if (rd_data_o !== 8'h55) begin miscompares++; $display("FAIL basic_head: got %h want 55", rd_data_o); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    vectors++; if (rd_data_o !== 8'hAA) begin miscompares++; $display("FAIL basic_second: got %h want aa", rd_data_o); end
    vectors++; if (level_o !== 5'd1) begin miscompares++; $display("FAIL basic_level1: got %0d want 1", level_o); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL basic_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_empty_push_pop;
    drive_cycle(1'b1, 8'h5A, 1'b1);
    vectors++; if (level_o !== 5'd1) begin miscompares++; $display("FAIL emptypp_level: got %0d want 1", level_o); end
    vectors++; if (rd_data_o !== 8'h5A) begin miscompares++; $display("FAIL emptypp_data: got %h want 5a", rd_data_o); end
    drive_cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overrun;
    for (int i = 0; i <= 16; i++) drive_cycle(1'b1, 8'(i), 1'b0);
    vectors++; if (full_o !== 1'b1) begin miscompares++; $display("FAIL ovr_full: got %b want 1", full_o); end
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
    vectors++; if (level_o !== 5'd16) begin miscompares++; $display("FAIL ovr_level: got %0d want 16", level_o); end
    // a new drop together with a clear keeps the flag set
    clr_overrun_i = 1'b1;
    drive_cycle(1'b1, 8'h99, 1'b0);
    clr_overrun_i = 1'b0;
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_set_priority: got %b want 1", overrun_o); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (sb.size() == 0 || rd_data_o !== sb[0] || rd_data_o !== 8'(i)) begin
        miscompares++; $display("FAIL ovr_pop%0d: got %h want %h", i, rd_data_o, 8'(i));
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL ovr_drained: got %b want 1", empty_o); end
    clr_overrun_i = 1'b1;
    idle(1);
    clr_overrun_i = 1'b0;
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    vectors++; if (rd_data_o !== 8'h20) begin miscompares++; $display("FAIL fpp_head: got %h want 20", rd_data_o); end
    drive_cycle(1'b1, 8'h77, 1'b1);
    vectors++; if (level_o !== 5'd16) begin miscompares++; $display("FAIL fpp_level: got %0d want 16", level_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL fpp_overrun: got %b want 0", overrun_o); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] want;
      want = (i == 15) ? 8'h77 : 8'h21 + 8'(i);
      vectors++;
      if (sb.size() == 0 || rd_data_o !== sb[0] || rd_data_o !== want) begin
        miscompares++; $display("FAIL fpp_pop%0d: got %h want %h", i, rd_data_o, want);
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL fpp_drained: got %b want 1", empty_o); end
  endtask

  task automatic test_thresh;
    thresh_i = 5'd4;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    drive_cycle(1'b1, 8'hA3, 1'b0);
    vectors++; if (level_o !== 5'd4) begin miscompares++; $display("FAIL thr_level4: got %0d want 4", level_o); end
    vectors++; if (thresh_irq_o !== 1'b0) begin miscompares++; $display("FAIL thr_not_yet: got %b want 0", thresh_irq_o); end
    idle(1);
    vectors++; if (thresh_irq_o !== 1'b1) begin miscompares++; $display("FAIL thr_rise: got %b want 1", thresh_irq_o); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    vectors++; if (thresh_irq_o !== 1'b1) begin miscompares++; $display("FAIL thr_lag: got %b want 1", thresh_irq_o); end
    idle(1);
    vectors++; if (thresh_irq_o !== 1'b0) begin miscompares++; $display("FAIL thr_fall: got %b want 0", thresh_irq_o); end
    thresh_i = 5'd0;
    idle(1);
    vectors++; if (thresh_irq_o !== 1'b0) begin miscompares++; $display("FAIL thr_zero: got %b want 0", thresh_irq_o); end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (rd_data_o !== 8'hA0 + 8'(i)) begin miscompares++; $display("FAIL thr_pop%0d: got %h want %h", i, rd_data_o, 8'hA0 + 8'(i)); end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_timeout;
    drive_cycle(1'b1, 8'h3C, 1'b0);
    idle(TO - 1);
    vectors++; if (timeout_irq_o !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b want 0", timeout_irq_o); end
    idle(1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    vectors++; if (timeout_irq_o !== 1'b1) begin miscompares++; $display("FAIL to_fire: got %b want 1", timeout_irq_o); end
    idle(5);
    vectors++; if (timeout_irq_o !== 1'b1) begin miscompares++; $display("FAIL to_hold: got %b want 1", timeout_irq_o); end
`else
    vectors++; if (timeout_irq_o !== 1'b0) begin miscompares++; $display("FAIL to_tied: got %b want 0", timeout_irq_o); end
`endif
    vectors++; if (rd_data_o !== 8'h3C) begin miscompares++; $display("FAIL to_data: got %h want 3c", rd_data_o); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    vectors++; if (timeout_irq_o !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", timeout_irq_o); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 17; i++) drive_cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 11; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    vectors++; if (level_o !== 5'd5) begin miscompares++; $display("FAIL fl_level5: got %0d want 5", level_o); end
    vectors++; if (rd_data_o !== 8'h4B) begin miscompares++; $display("FAIL fl_head: got %h want 4b", rd_data_o); end
    cfg_en_i = 1'b0;
    #1;
    vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL fl_ready: got %b want 0", in_ready_o); end
    drive_cycle(1'b1, 8'hEE, 1'b0);
    cfg_en_i = 1'b1;
    sb.delete();
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL fl_empty: got %b want 1", empty_o); end
    vectors++; if (level_o !== 5'd0) begin miscompares++; $display("FAIL fl_level0: got %0d want 0", level_o); end
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL fl_overrun_kept: got %b want 1", overrun_o); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    sb.delete();
    vectors++; if (level_o !== 5'd0) begin miscompares++; $display("FAIL mr_level: got %0d want 0", level_o); end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL mr_empty: got %b want 1", empty_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL mr_overrun: got %b want 0", overrun_o); end
    drive_cycle(1'b1, 8'h42, 1'b0);
    vectors++; if (rd_data_o !== 8'h42) begin miscompares++; $display("FAIL mr_fresh: got %h want 42", rd_data_o); end
    vectors++; if (level_o !== 5'd1) begin miscompares++; $display("FAIL mr_level1: got %0d want 1", level_o); end
  endtask

  initial begin
    rst = 1'b0; cfg_en_i = 1'b0; in_data_i = 8'h00; in_valid_i = 1'b0;
    rd_en_i = 1'b0; thresh_i = '0; clr_overrun_i = 1'b0;
    test_reset();
    test_basic();
    test_empty_push_pop();
    test_overrun();
    test_full_push_pop();
    test_thresh();
    test_timeout();
    test_flush();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
